sm_event_sink: RTL and testbench

// - Receiving end of the surveillance event stream: consumes DI debug-event packets produced by

---
 rtl/sm_pkg.sv | 46 ++++
 rtl/sm_event_parser.sv | 130 +++++++++++++
 rtl/sm_event_sink.sv | 140 ++++++++++++++
 tb/tb_sm_event_sink.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared types and constants for the surveillance event sink: flit format,
// record kinds, parser states, register map and the saturating accumulate.
package sm_pkg;

   localparam int NUM_KINDS = 5;
   localparam int HDR_WORDS = 3;
   localparam int REC_WORDS = 3;

   localparam logic [1:0]  TYPE_EVENT    = 2'b10;

   localparam logic [31:0] WB_STATUS     = 32'h0000_0000;
   localparam logic [31:0] WB_EVENT_CNT  = 32'h0000_0004;
   localparam logic [31:0] WB_TABLE_BASE = 32'h0000_0100;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

   typedef enum logic [3:0] {
      KIND_BE_SEND  = 4'd0,
      KIND_BE_RECV  = 4'd1,
      KIND_TDM_SEND = 4'd2,
      KIND_TDM_RECV = 4'd3,
      KIND_FAULTY   = 4'd4
   } sm_kind_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SRC,
      ST_TYPE,
      ST_R_IDX,
      ST_R_LO,
      ST_R_HI,
      ST_DROP
   } sm_state_t;

   // Counters stick at all-ones rather than wrapping back to small values.
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/sm_event_parser.sv
// Walks one DI event packet word by word and emits one accumulate request
// per well-formed statistics record, plus packet/record error strobes.
module sm_event_parser
   import sm_pkg::*;
#(
   parameter int NUM_TILES         = 9,
   parameter int NUM_TDM_ENDPOINTS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  dii_flit     flit,
   input  logic        flit_ready,
   output logic        acc_valid,
   output logic [3:0]  acc_kind,
   output logic [11:0] acc_idx,
   output logic [31:0] acc_value,
   output logic        evt_done,
   output logic        rec_err,
   output logic        pkt_err
);

   localparam logic [11:0] TILES_LIM = 12'(NUM_TILES);
   localparam logic [11:0] TDM_LIM   = 12'(NUM_TDM_ENDPOINTS);

   sm_state_t   state_q, state_d;
   logic [3:0]  rec_kind_q;
   logic [11:0] rec_idx_q;
   logic [15:0] rec_lo_q;
   logic        take;
   logic        rec_ok;

   assign take = flit.valid & flit_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         rec_kind_q <= '0;
         rec_idx_q  <= '0;
         rec_lo_q   <= '0;
      end else begin
         state_q <= state_d;
         if (take && state_q == ST_R_IDX) begin
            rec_kind_q <= flit.data[15:12];
            rec_idx_q  <= flit.data[11:0];
         end
         if (take && state_q == ST_R_LO) begin
            rec_lo_q <= flit.data;
         end
      end
   end

   // The idx bound depends on whether the kind counts tiles or TDM endpoints.
   always_comb begin
      rec_ok = 1'b0;
      case (rec_kind_q)
         KIND_BE_SEND, KIND_BE_RECV, KIND_FAULTY: rec_ok = (rec_idx_q < TILES_LIM);
         KIND_TDM_SEND, KIND_TDM_RECV:            rec_ok = (rec_idx_q < TDM_LIM);
         default:                                 rec_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      acc_valid = 1'b0;
      evt_done  = 1'b0;
      rec_err   = 1'b0;
      pkt_err   = 1'b0;
      if (take) begin
         case (state_q)
            ST_IDLE: begin
               if (flit.last) pkt_err = 1'b1;
               else           state_d = ST_SRC;
            end
            ST_SRC: begin
               if (flit.last) begin
                  pkt_err = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_TYPE;
               end
            end
            ST_TYPE: begin
               if (flit.last) begin
                  pkt_err = 1'b1;
                  state_d = ST_IDLE;
               end else if (flit.data[15:14] != TYPE_EVENT) begin
                  state_d = ST_DROP;
               end else begin
                  state_d = ST_R_IDX;
               end
            end
            ST_R_IDX: begin
               if (flit.last) begin
                  pkt_err = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_R_LO;
               end
            end
            ST_R_LO: begin
               if (flit.last) begin
                  pkt_err = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_R_HI;
               end
            end
            ST_R_HI: begin
               acc_valid = rec_ok;
               rec_err   = ~rec_ok;
               if (flit.last) begin
                  evt_done = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d  = ST_R_IDX;
               end
            end
            ST_DROP: begin
               if (flit.last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign acc_kind  = rec_kind_q;
   assign acc_idx   = rec_idx_q;
   assign acc_value = {flit.data, rec_lo_q};

endmodule

// File: rtl/sm_event_sink.sv
// Monitor-tile event sink: parses DI statistic packets into a per-kind counter
// table and exposes table, counters and an event interrupt on a wishbone slave.
module sm_event_sink
   import sm_pkg::*;
#(
   parameter int NUM_TILES         = 9,
   parameter int NUM_TDM_ENDPOINTS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  dii_flit     debug_in,
   output logic        debug_in_ready,
   input  logic [31:0] wb_addr,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [31:0] wb_data_in,
   output logic        wb_ack,
   output logic        wb_err,
   output logic [31:0] wb_data_out,
   output logic        irq
);

   localparam int SLOTS = (NUM_TILES > NUM_TDM_ENDPOINTS) ? NUM_TILES : NUM_TDM_ENDPOINTS;
   localparam int ENTRIES = NUM_KINDS * SLOTS;
   localparam logic [31:0] TABLE_BYTES = 32'(4 * ENTRIES);

   logic        acc_valid;
   logic [3:0]  acc_kind;
   logic [11:0] acc_idx;
   logic [31:0] acc_value;
   logic        evt_done, rec_err, pkt_err;
   int          acc_entry;

   logic [31:0] cnt_table [ENTRIES];
   logic [31:0] tbl_d     [ENTRIES];
   logic [31:0] evt_cnt_q;
   logic [7:0]  err_cnt_q;

   logic        wb_req, is_status, is_evt, is_table, acc_ok;
   logic        wb_clear, status_rd;
   logic [31:0] tbl_off, rd_tbl, rd_data;
   int          tbl_idx;
   logic        unused_wdata;

   // DI handshake: a flit transfers on any clock where valid and ready are both
   // high; ready is a registered constant that only drops while in reset.
   always_ff @(posedge clk) begin
      if (!rst) debug_in_ready <= 1'b0;
      else      debug_in_ready <= 1'b1;
   end

   sm_event_parser #(
      .NUM_TILES         (NUM_TILES),
      .NUM_TDM_ENDPOINTS (NUM_TDM_ENDPOINTS)
   ) u_parser (
      .clk        (clk),
      .rst        (rst),
      .flit       (debug_in),
      .flit_ready (debug_in_ready),
      .acc_valid  (acc_valid),
      .acc_kind   (acc_kind),
      .acc_idx    (acc_idx),
      .acc_value  (acc_value),
      .evt_done   (evt_done),
      .rec_err    (rec_err),
      .pkt_err    (pkt_err)
   );

   assign acc_entry = int'(acc_kind) * SLOTS + int'(acc_idx);

   // Write data carries no meaning: any write to a table entry clears it.
   assign unused_wdata = ^wb_data_in;

   // A new request is only taken once the previous response pulse has gone.
   assign wb_req    = wb_cyc & wb_stb & ~wb_ack & ~wb_err;
   assign tbl_off   = wb_addr - WB_TABLE_BASE;
   assign tbl_idx   = int'({2'b00, tbl_off[31:2]});
   assign is_status = (wb_addr == WB_STATUS);
   assign is_evt    = (wb_addr == WB_EVENT_CNT);
   assign is_table  = (wb_addr >= WB_TABLE_BASE) && (tbl_off < TABLE_BYTES) &&
                      (wb_addr[1:0] == 2'b00);
   assign acc_ok    = is_table | ((is_status | is_evt) & ~wb_we);
   assign wb_clear  = wb_req & is_table & wb_we;
   assign status_rd = wb_req & is_status & ~wb_we;

   always_comb begin
      rd_tbl = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (tbl_idx == i) rd_tbl = cnt_table[i];
      end
      rd_data = '0;
      if (is_status)     rd_data = {16'h0000, err_cnt_q, 7'h00, irq};
      else if (is_evt)   rd_data = evt_cnt_q;
      else if (is_table) rd_data = rd_tbl;
   end

   // Clear is applied before the add so a same-cycle clear keeps the new record.
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         tbl_d[i] = cnt_table[i];
         if (wb_clear && tbl_idx == i)    tbl_d[i] = '0;
         if (acc_valid && acc_entry == i) tbl_d[i] = sat_add32(tbl_d[i], acc_value);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) cnt_table[i] <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) cnt_table[i] <= tbl_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         evt_cnt_q <= '0;
         err_cnt_q <= '0;
         irq       <= 1'b0;
      end else begin
         if (evt_done) evt_cnt_q <= evt_cnt_q + 32'd1;
         if ((rec_err | pkt_err) && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
         if (evt_done)       irq <= 1'b1;
         else if (status_rd) irq <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_ack      <= 1'b0;
         wb_err      <= 1'b0;
         wb_data_out <= '0;
      end else begin
         wb_ack <= wb_req & acc_ok;
         wb_err <= wb_req & ~acc_ok;
         if (wb_req) wb_data_out <= (acc_ok & ~wb_we) ? rd_data : 32'h0;
      end
   end

endmodule

// File: tb/tb_sm_event_sink.sv
// Bench for sm_event_sink: directed packets plus randomized traffic checked
// against a packet-level reference model of the counter table and registers.
module tb_sm_event_sink;
   import sm_pkg::*;

   localparam int SLOTS   = 9;
   localparam int ENTRIES = 5 * SLOTS;

   logic        clk = 1'b0;
   logic        rst;
   dii_flit     debug_in;
   logic        debug_in_ready;
   logic [31:0] wb_addr;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_data_in;
   logic        wb_ack, wb_err;
   logic [31:0] wb_data_out;
   logic        irq;

   always #5 clk = ~clk;

   sm_event_sink #(
      .NUM_TILES         (9),
      .NUM_TDM_ENDPOINTS (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .debug_in       (debug_in),
      .debug_in_ready (debug_in_ready),
      .wb_addr        (wb_addr),
      .wb_cyc         (wb_cyc),
      .wb_stb         (wb_stb),
      .wb_we          (wb_we),
      .wb_data_in     (wb_data_in),
      .wb_ack         (wb_ack),
      .wb_err         (wb_err),
      .wb_data_out    (wb_data_out),
      .irq            (irq)
   );

   int          n_vec = 0;
   int          n_mis = 0;
   logic [31:0] m_table [ENTRIES];
   logic [31:0] m_evt;
   int          m_err;
   logic        m_irq;
   logic [15:0] pkt_q [$];
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (whole-packet view) ----------------
   function automatic void model_reset();
      for (int i = 0; i < ENTRIES; i++) m_table[i] = '0;
      m_evt = '0;
      m_err = 0;
      m_irq = 1'b0;
   endfunction

   function automatic void model_err();
      if (m_err < 255) m_err++;
   endfunction

   function automatic bit rec_valid(input int k, input int idx);
      if (k == 0 || k == 1 || k == 4) return idx < 9;
      if (k == 2 || k == 3) return idx < 4;
      return 1'b0;
   endfunction

   function automatic void model_apply();
      int n, nrec, rem, k, idx, e;
      logic [15:0] w0, w1, w2;
      longint sum;
      n = pkt_q.size();
      if (n <= HDR_WORDS) begin
         model_err();
         return;
      end
      w0 = pkt_q[2];
      if (w0[15:14] != 2'b10) return;
      nrec = (n - HDR_WORDS) / REC_WORDS;
      rem  = (n - HDR_WORDS) % REC_WORDS;
      for (int r = 0; r < nrec; r++) begin
         w0  = pkt_q[HDR_WORDS + REC_WORDS * r];
         w1  = pkt_q[HDR_WORDS + REC_WORDS * r + 1];
         w2  = pkt_q[HDR_WORDS + REC_WORDS * r + 2];
         k   = int'(w0[15:12]);
         idx = int'(w0[11:0]);
         if (rec_valid(k, idx)) begin
            e   = k * SLOTS + idx;
            sum = longint'(m_table[e]) + longint'({w2, w1});
            m_table[e] = (sum > 64'd4294967295) ? 32'hFFFF_FFFF : sum[31:0];
         end else begin
            model_err();
         end
      end
      if (rem != 0) model_err();
      else begin
         m_evt = m_evt + 32'd1;
         m_irq = 1'b1;
      end
   endfunction

   function automatic logic [31:0] exp_status();
      return {16'h0000, 8'(m_err), 7'h00, m_irq};
   endfunction

   // ---------------- drivers ----------------
   task automatic send_flit(input logic [15:0] w, input logic l, input int gap_max);
      int gap;
      gap = $urandom_range(0, gap_max);
      @(negedge clk);
      if (gap > 0) begin
         debug_in.valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      debug_in = '{valid: 1'b1, last: l, data: w};
      @(posedge clk);
   endtask

   task automatic send_pkt();
      for (int i = 0; i < pkt_q.size(); i++) send_flit(pkt_q[i], i == pkt_q.size() - 1, 2);
      @(negedge clk);
      debug_in = '0;
      model_apply();
   endtask

   task automatic wb_xfer(input logic [31:0] addr, input logic we,
                          output logic [31:0] rdata, output logic ack, output logic err);
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_data_in = $urandom;
      @(posedge clk);
      @(negedge clk);
      ack = wb_ack; err = wb_err; rdata = wb_data_out;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   task automatic wb_read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      logic ack, err;
      exp_q.push_back(exp);
      wb_xfer(addr, 1'b0, rd, ack, err);
      check({tag, "_resp"}, {30'h0, ack, err}, 32'h2);
      check(tag, rd, exp_q.pop_front());
   endtask

   task automatic read_status(input string tag);
      wb_read_chk(tag, WB_STATUS, exp_status());
      m_irq = 1'b0;
   endtask

   task automatic wb_clear_chk(input string tag, input int n);
      logic [31:0] rd;
      logic ack, err;
      wb_xfer(32'h100 + 32'(4 * n), 1'b1, rd, ack, err);
      check(tag, {30'h0, ack, err}, 32'h2);
      m_table[n] = '0;
   endtask

   task automatic push_rec(input logic [15:0] head, input logic [31:0] cnt);
      pkt_q.push_back(head);
      pkt_q.push_back(cnt[15:0]);
      pkt_q.push_back(cnt[31:16]);
   endtask

   task automatic gen_pkt();
      int sel, nrec, k, lim, idx, cut;
      logic [31:0] cnt;
      logic [1:0] tt;
      sel = $urandom_range(0, 9);
      pkt_q.delete();
      pkt_q.push_back(16'($urandom));
      pkt_q.push_back(16'($urandom));
      if (sel <= 8 && sel >= 7) begin
         tt = ($urandom_range(0, 2) == 2) ? 2'b11 : 2'($urandom_range(0, 1));
         pkt_q.push_back({tt, 14'($urandom)});
         repeat ($urandom_range(1, 6)) pkt_q.push_back(16'($urandom));
      end else begin
         pkt_q.push_back({2'b10, 14'($urandom)});
         nrec = (sel == 9) ? $urandom_range(0, 2) : $urandom_range(1, 3);
         for (int r = 0; r < nrec; r++) begin
            k   = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 15) : $urandom_range(0, 4);
            lim = (k == 2 || k == 3) ? 4 : 9;
            idx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, lim - 1);
            cnt = {($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0, 16'($urandom)};
            push_rec({4'(k), 12'(idx)}, cnt);
         end
         if (sel == 9) begin
            repeat ($urandom_range(1, 2)) pkt_q.push_back(16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
               cut = $urandom_range(1, 3);
               while (pkt_q.size() > cut) void'(pkt_q.pop_back());
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic ack, err;
      int r, n;

      debug_in = '0; wb_addr = '0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_data_in = '0;
      rst = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(debug_in_ready), 32'h0);
      check("rst_irq",   32'(irq), 32'h0);
      check("rst_resp",  {30'h0, wb_ack, wb_err}, 32'h0);
      check("rst_rdata", wb_data_out, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("ready", 32'(debug_in_ready), 32'h1);

      // partial packet, then reset mid-packet; the next packet must parse cleanly
      pkt_q = '{16'h0001, 16'h0002, 16'h8000, 16'h0003};
      for (int i = 0; i < 4; i++) send_flit(pkt_q[i], 1'b0, 0);
      @(negedge clk);
      debug_in = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();

      pkt_q = '{16'h0011, 16'h0022, 16'h8000, 16'h0003, 16'd5, 16'd0, 16'h1002, 16'd7, 16'd0};
      send_pkt();
      check("t1_irq", 32'(irq), 32'h1);
      wb_read_chk("t1_e3", 32'h100 + 32'(4 * 3), 32'd5);
      wb_read_chk("t1_e11", 32'h100 + 32'(4 * (SLOTS + 2)), 32'd7);
      wb_read_chk("t1_evt", WB_EVENT_CNT, 32'd1);

      // stb held for three cycles: ack, gap, ack
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = WB_EVENT_CNT;
      @(posedge clk); @(negedge clk);
      check("hold_ack1", {31'h0, wb_ack}, 32'h1);
      check("hold_data", wb_data_out, 32'd1);
      @(posedge clk); @(negedge clk);
      check("hold_gap", {30'h0, wb_ack, wb_err}, 32'h0);
      @(posedge clk); @(negedge clk);
      check("hold_ack2", {31'h0, wb_ack}, 32'h1);
      wb_cyc = 1'b0; wb_stb = 1'b0;

      wb_read_chk("stat_irq", WB_STATUS, 32'h0000_0001);
      m_irq = 1'b0;
      check("stat_irq_clr", 32'(irq), 32'h0);

      wb_xfer(32'h800, 1'b0, rd, ack, err);
      check("bad_addr", {30'h0, ack, err}, 32'h1);
      @(negedge clk);
      check("bad_pulse", {30'h0, wb_ack, wb_err}, 32'h0);
      wb_xfer(WB_EVENT_CNT, 1'b1, rd, ack, err);
      check("wr_evt", {30'h0, ack, err}, 32'h1);
      wb_xfer(WB_STATUS, 1'b1, rd, ack, err);
      check("wr_stat", {30'h0, ack, err}, 32'h1);
      wb_xfer(32'h100 + 32'(4 * ENTRIES), 1'b0, rd, ack, err);
      check("tbl_end", {30'h0, ack, err}, 32'h1);

      // saturation on the last entry (FAULTY, idx 8)
      wb_clear_chk("sat_clr", 44);
      pkt_q = '{16'h0, 16'h1, 16'h8000, 16'h4008, 16'hFFF0, 16'hFFFF};
      send_pkt();
      pkt_q = '{16'h0, 16'h1, 16'h8000, 16'h4008, 16'h0020, 16'h0000};
      send_pkt();
      wb_read_chk("sat", 32'h100 + 32'(4 * 44), 32'hFFFF_FFFF);

      // non-event type packet: swallowed without counting or error
      pkt_q = '{16'h0, 16'h1, 16'h4000, 16'h0000, 16'd1, 16'd0, 16'h0003, 16'd1, 16'd0};
      send_pkt();
      check("drop_idle", 32'(dut.u_parser.state_q), 32'(ST_IDLE));
      wb_read_chk("drop_e0", 32'h100, 32'd0);
      wb_read_chk("drop_e3", 32'h100 + 32'(4 * 3), 32'd5);
      read_status("drop_stat");

      // bad kind record plus truncation on R_LO
      pkt_q = '{16'h0, 16'h1, 16'h8000, 16'h0001, 16'd3, 16'd0, 16'h7000, 16'd1, 16'd0,
                16'h0002, 16'd4};
      send_pkt();
      check("err_irq", 32'(irq), 32'h0);
      wb_read_chk("err_stat", WB_STATUS, 32'h0000_0200);
      wb_read_chk("err_e1", 32'h100 + 32'(4 * 1), 32'd3);
      wb_read_chk("err_e2", 32'h100 + 32'(4 * 2), 32'd0);

      // clear of entry 3 coinciding with an accumulate into it
      pkt_q = '{16'h0, 16'h1, 16'h8000, 16'h0003, 16'd4, 16'd0};
      send_pkt();
      wb_read_chk("sim_pre", 32'h100 + 32'(4 * 3), 32'd9);
      for (int i = 0; i < 5; i++) send_flit(pkt_q[i], 1'b0, 1);
      @(negedge clk);
      debug_in = '{valid: 1'b1, last: 1'b1, data: pkt_q[5]};
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 32'h100 + 32'(4 * 3);
      @(posedge clk); @(negedge clk);
      check("sim_resp", {30'h0, wb_ack, wb_err}, 32'h2);
      debug_in = '0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      m_table[3] = '0;
      model_apply();
      wb_read_chk("sim_e3", 32'h100 + 32'(4 * 3), 32'd4);

      // randomized traffic against the model
      for (int p = 0; p < 80; p++) begin
         gen_pkt();
         send_pkt();
         check("rnd_irq", 32'(irq), 32'(m_irq));
         r = $urandom_range(0, 5);
         if (r == 0) begin
            n = $urandom_range(0, ENTRIES - 1);
            wb_read_chk("rnd_tbl", 32'h100 + 32'(4 * n), m_table[n]);
         end else if (r == 1) begin
            read_status("rnd_stat");
         end else if (r == 2) begin
            wb_clear_chk("rnd_clr", $urandom_range(0, ENTRIES - 1));
         end
      end

      for (int i = 0; i < ENTRIES; i++) wb_read_chk($sformatf("fin_e%0d", i), 32'h100 + 32'(4 * i), m_table[i]);
      wb_read_chk("fin_evt", WB_EVENT_CNT, m_evt);
      read_status("fin_stat");
      check("fin_irq", 32'(irq), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
